// File: rtl/fp_sqrt_post_pipe.sv
// Rounding and renormalisation stage behind the sqrt iteration core, followed by an elastic
// valid/retry register pipe. Optional flush port enabled by defining FP_SQRT_POST_FLUSH_EN.
`ifndef FP_MAN_BITS
`define FP_MAN_BITS 53
`endif
`ifndef FP_EXP_BITS
`define FP_EXP_BITS 11
`endif
`ifndef FP_PREDEC_BITS
`define FP_PREDEC_BITS 8
`endif
`ifndef FP_STATE_BITS
`define FP_STATE_BITS 4
`endif

module fp_sqrt_post_pipe #(
  parameter int MAN_BITS    = `FP_MAN_BITS,
  parameter int EXP_BITS    = `FP_EXP_BITS,
  parameter int PREDEC_BITS = `FP_PREDEC_BITS,
  parameter int STATE_BITS  = `FP_STATE_BITS,
  parameter int STAGES      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sqrtp_valid,
  output logic                   sqrtp_retry,
  input  logic [PREDEC_BITS-1:0] sqrtp_op_predec,
  input  logic [STATE_BITS-1:0]  sqrtp_state,
  input  logic [1:0]             sqrtp_round,
  input  logic                   sqrtp_sign,
  input  logic [EXP_BITS-1:0]    sqrtp_exp,
  input  logic [MAN_BITS+1:0]    sqrtp_man,
  output logic                   sqrt_valid,
  input  logic                   sqrt_retry,
  output logic [PREDEC_BITS-1:0] sqrt_op_predec,
  output logic [STATE_BITS-1:0]  sqrt_state,
  output logic [1:0]             sqrt_round,
  output logic                   sqrt_sign,
  output logic [EXP_BITS-1:0]    sqrt_exp,
  output logic [MAN_BITS-1:0]    sqrt_man,
  output logic                   sqrt_inexact
`ifdef FP_SQRT_POST_FLUSH_EN
  ,
  input  logic                   flush
`endif
);

  localparam int DW = PREDEC_BITS + STATE_BITS + 2 + 1 + EXP_BITS + MAN_BITS + 1;

  logic flush_i;
`ifdef FP_SQRT_POST_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  logic              lsb, guard, sticky, inc, carry;
  logic [MAN_BITS:0] sum;
  logic [MAN_BITS-1:0] man_r;
  logic [EXP_BITS-1:0] exp_r;

  assign lsb    = sqrtp_man[2];
  assign guard  = sqrtp_man[1];
  assign sticky = sqrtp_man[0];

  always_comb begin
    inc = 1'b0;
    case (sqrtp_round)
      2'd0: inc = guard & (sticky | lsb);
      2'd1: inc = 1'b0;
      2'd2: inc = ~sqrtp_sign & (guard | sticky);
      2'd3: inc = sqrtp_sign & (guard | sticky);
      default: inc = 1'b0;
    endcase
  end

  // A carry out of the mantissa can only come from all-ones + 1, so the result is exactly 1.0.
  assign sum   = {1'b0, sqrtp_man[MAN_BITS+1:2]} + {{MAN_BITS{1'b0}}, inc};
  assign carry = sum[MAN_BITS];
  assign man_r = carry ? {1'b1, {(MAN_BITS-1){1'b0}}} : sum[MAN_BITS-1:0];
  assign exp_r = sqrtp_exp + {{(EXP_BITS-1){1'b0}}, carry};

  logic [DW-1:0] din;
  assign din = {sqrtp_op_predec, sqrtp_state, sqrtp_round, sqrtp_sign, exp_r, man_r,
                guard | sticky};

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] load;
  logic [DW-1:0]     dat [STAGES];
  logic              accept;

  // load[i] = stage i is empty or drains this cycle; reduces to a ripple from the output end.
  always_comb begin
    logic ld;
    ld = ~vld[STAGES-1] | ~sqrt_retry;
    load = '0;
    load[STAGES-1] = ld;
    for (int i = STAGES - 2; i >= 0; i--) begin
      ld = ~vld[i] | ld;
      load[i] = ld;
    end
  end

  assign sqrtp_retry = ~load[0] & ~flush_i;
  assign accept      = sqrtp_valid & ~sqrtp_retry & ~flush_i;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic          src_v, v_q;
    logic [DW-1:0] src_d, d_q;

    if (i == 0) begin : g_src
      assign src_v = accept;
      assign src_d = din;
    end else begin : g_src
      assign src_v = vld[i-1];
      assign src_d = dat[i-1];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (flush_i) begin
        v_q <= 1'b0;
      end else if (load[i]) begin
        v_q <= src_v;
        if (src_v) d_q <= src_d;
      end
    end

    assign vld[i] = v_q;
    assign dat[i] = d_q;
  end

  assign sqrt_valid = vld[STAGES-1];
  assign {sqrt_op_predec, sqrt_state, sqrt_round, sqrt_sign, sqrt_exp, sqrt_man,
          sqrt_inexact} = dat[STAGES-1];

endmodule
